// File: rtl/laji_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : laji_pipe_stage_chain
// Purpose  : Parametrised chain of pipeline stage registers. Each stage can
//            be stalled or flushed. Holds propagate back toward stage 0, and
//            a stage whose upstream is held loads a bubble. With COLLAPSE=1
//            an empty stage never holds, so bubbles are squeezed out.
//            Saturating retire and stall performance counters are included.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            en_i              - global enable (0 freezes all state)
//            in_valid_i/in_data_i/in_ready_o - stage 0 input side
//            stall_i/flush_i   - per-stage stall and flush requests
//            cnt_clr_i         - synchronous clear of both counters
//            stage_data_o/stage_valid_o - registered stage contents
//            stage_hold_o      - combinational effective hold per stage
//            retire_cnt_o/stall_cnt_o   - saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module laji_pipe_stage_chain #(
  parameter int STAGES   = 4,
  parameter int WIDTH    = 32,
  parameter int COLLAPSE = 0,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    in_valid_i,
  input  logic [WIDTH-1:0]        in_data_i,
  output logic                    in_ready_o,
  input  logic [STAGES-1:0]       stall_i,
  input  logic [STAGES-1:0]       flush_i,
  input  logic                    cnt_clr_i,
  output logic [STAGES*WIDTH-1:0] stage_data_o,
  output logic [STAGES-1:0]       stage_valid_o,
  output logic [STAGES-1:0]       stage_hold_o,
  output logic [CNT_W-1:0]        retire_cnt_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]             retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  logic [STAGES:0]              w_hold_chain;
  logic [STAGES-1:0]            w_hold;
  logic                         w_src_valid [STAGES];
  logic [WIDTH-1:0]             w_src_data  [STAGES];
  logic                         w_retire;
  logic                         w_stall;

  // Hold ripples from the last stage back toward stage 0; the slot past the
  // last stage never holds.
  always_comb begin
    w_hold_chain = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (COLLAPSE != 0) begin
        w_hold_chain[i] = valid_q[i] & (stall_i[i] | w_hold_chain[i+1]);
      end else begin
        w_hold_chain[i] = stall_i[i] | w_hold_chain[i+1];
      end
    end
  end

  assign w_hold = w_hold_chain[STAGES-1:0];

  // Upstream source for each stage. A held upstream stage offers a bubble so
  // its payload is never duplicated downstream.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
    if (gi == 0) begin : g_head
      assign w_src_valid[gi] = in_valid_i;
      assign w_src_data[gi]  = in_data_i;
    end else begin : g_body
      assign w_src_valid[gi] = valid_q[gi-1] & ~w_hold[gi-1];
      assign w_src_data[gi]  = w_hold[gi-1] ? '0 : data_q[gi-1];
    end
  end

  // Flush wins over hold so a held stage can still be turned into a bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush_i[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = '0;
      end else if (!w_hold[i]) begin
        valid_d[i] = w_src_valid[i];
        data_d[i]  = w_src_data[i];
      end
    end
  end

  assign w_retire = valid_q[STAGES-1] & ~w_hold[STAGES-1];
  assign w_stall  = w_hold[0];

  // Clear works regardless of enable; increments stop at all-ones.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (cnt_clr_i) begin
      retire_cnt_d = '0;
      stall_cnt_d  = '0;
    end else if (en_i) begin
      if (w_retire && !(&retire_cnt_q)) begin
        retire_cnt_d = retire_cnt_q + c_CNT_ONE;
      end
      if (w_stall && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      data_q       <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (en_i) begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign in_ready_o    = en_i & ~w_hold[0];
  assign stage_data_o  = data_q;
  assign stage_valid_o = valid_q;
  assign stage_hold_o  = w_hold;
  assign retire_cnt_o  = retire_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
`default_nettype wire
